crop_ctrl: RTL and testbench
============================

Name: crop_ctrl

Overview:
Frame-level controller and sequencer for the crop datapath on the camera pixel stream. Accepts crop-window configuration over a handshake and validates it. Applies new windows only at frame boundaries, tracks row/column position, and forwards in-window pixels through a one-stage output register. Output beats carry start-of-frame, end-of-line and end-of-frame markers.

Parameters:
PIXEL_BIT_WIDTH, 12, pixel data width
IN_ROWS, 40, rows per input frame
IN_COLS, 40, columns per input frame
COL_W, $clog2(IN_COLS+1), width of column coordinate/size fields (derived)
ROW_W, $clog2(IN_ROWS+1), width of row coordinate/size fields (derived)

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
pixel_in  in  PIXEL_BIT_WIDTH  input pixel
in_valid  in  1  input beat valid
in_sof  in  1  input beat is pixel (0,0) of a frame; qualified by in_valid
in_ready  out  1  input beat accepted when in_valid && in_ready
pixel_out  out  PIXEL_BIT_WIDTH  cropped pixel
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_sof  out  1  first pixel of cropped frame
out_eol  out  1  last pixel of a cropped row
out_eof  out  1  last pixel of cropped frame
cfg_valid  in  1  config request
cfg_ready  out  1  config slot free
cfg_x1  in  COL_W  window left column
cfg_y1  in  ROW_W  window top row
cfg_cols  in  COL_W  window width
cfg_rows  in  ROW_W  window height
cfg_err  out  1  one-cycle pulse: config rejected
frame_err  out  1  one-cycle pulse: in_sof seen mid-frame
frame_done  out  1  one-cycle pulse: last input pixel of a frame accepted
active  out  1  a window is applied and a frame is in progress

Behaviour:
- Reset: state IDLE; out_valid, out_sof/eol/eof, cfg_err, frame_err, frame_done, active = 0; pending-config flag cleared; applied config invalid; x,y = 0. Reset mid-frame discards all state and config; the output beat in flight is dropped.
- Config: cfg_ready = !pending. Transfer on cfg_valid && cfg_ready.
  - Legal only if cols>=1, rows>=1, x1+cols<=IN_COLS, y1+rows<=IN_ROWS. Sums are computed one bit wider than operands.
  - Illegal config: accepted, discarded, cfg_err pulses next cycle. Pending is unchanged.
  - Legal config sets pending. A second config is blocked until pending is consumed.
- in_ready = !out_valid || out_ready in all states. Out-of-window pixels are consumed at the same rate and never stall on their own.
- FSM:
  - IDLE: no applied config; accepted pixels discarded. When pending is set, load it and go to ARMED; pending clears the same cycle.
  - ARMED: discard beats until an accepted beat with in_sof=1. That beat is processed as (0,0) in ACTIVE logic the same cycle; go to ACTIVE and assert active.
  - ACTIVE: each accepted beat is at (x,y); x wraps at IN_COLS-1 and increments y.
    - Window hit when y1<=y<y1+rows and x1<=x<x1+cols. A hit loads pixel_out and sets out_valid next cycle (latency 1).
    - Markers: sof at (x1,y1); eol at x=x1+cols-1; eof at (x1+cols-1, y1+rows-1).
    - Accepting (IN_COLS-1, IN_ROWS-1) pulses frame_done and clears x,y. If pending, load it; this takes effect from the next frame. Then go to ARMED and deassert active.
- out_valid holds, with data and markers stable, until out_ready. When out_valid && out_ready and no new hit, clear out_valid.
- in_sof in ACTIVE at a position other than (0,0):
  - pulse frame_err and resync to (0,0) with that beat;
  - no eof is emitted for the truncated frame;
  - the window stays the same unless pending, which is then loaded.
- in_sof while not ACTIVE is normal. in_sof is ignored when in_valid=0.
- Simultaneous config accept and frame-end load: the load uses the old pending value; the new config becomes pending.

Test Plan:
- Reset, then cfg (x1=10,y1=10,cols=20,rows=20), one 40x40 frame, out_ready=1 -> 400 beats, first out at cycle after input (10,10) with out_sof; out_eol on every 20th beat; out_eof on beat 400; frame_done once.
- cfg x1=30,cols=11 -> cfg_err pulse, cfg_ready stays 1, IDLE; following frame produces 0 output beats.
- Window (0,0,1,1) then out_ready held 0 for 5 cycles after first hit -> in_ready=0, pixel_out stable, no beats lost; single beat carries sof, eol and eof.
- Second cfg (x1=0,y1=0,cols=40,rows=40) sent mid-frame -> current frame still 20x20; next frame produces 1600 beats.
- in_sof asserted at input pixel 500 of a frame -> frame_err pulse, coordinates restart at (0,0), no out_eof for the aborted frame.
- reset asserted while out_valid=1 mid-frame -> next cycle out_valid=0, active=0, cfg_ready=1; frames discarded until new cfg.

Source files
------------

// File: rtl/crop_if.sv
// Pixel stream, output stream and crop-window configuration bundle for crop_ctrl.
// The master side drives input pixels, downstream ready and config requests.
interface crop_if #(
    parameter int PIXEL_BIT_WIDTH = 12,
    parameter int IN_ROWS         = 40,
    parameter int IN_COLS         = 40
);
    localparam int COL_W = $clog2(IN_COLS + 1);
    localparam int ROW_W = $clog2(IN_ROWS + 1);

    logic [PIXEL_BIT_WIDTH-1:0] pixel_in;
    logic                       in_valid;
    logic                       in_sof;
    logic                       in_ready;

    logic [PIXEL_BIT_WIDTH-1:0] pixel_out;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_sof;
    logic                       out_eol;
    logic                       out_eof;

    logic                       cfg_valid;
    logic                       cfg_ready;
    logic [COL_W-1:0]           cfg_x1;
    logic [ROW_W-1:0]           cfg_y1;
    logic [COL_W-1:0]           cfg_cols;
    logic [ROW_W-1:0]           cfg_rows;
    logic                       cfg_err;

    logic                       frame_err;
    logic                       frame_done;
    logic                       active;

    modport master (
        output pixel_in, in_valid, in_sof, out_ready,
        output cfg_valid, cfg_x1, cfg_y1, cfg_cols, cfg_rows,
        input  in_ready, pixel_out, out_valid, out_sof, out_eol, out_eof,
        input  cfg_ready, cfg_err, frame_err, frame_done, active
    );

    modport slave (
        input  pixel_in, in_valid, in_sof, out_ready,
        input  cfg_valid, cfg_x1, cfg_y1, cfg_cols, cfg_rows,
        output in_ready, pixel_out, out_valid, out_sof, out_eol, out_eof,
        output cfg_ready, cfg_err, frame_err, frame_done, active
    );
endinterface

// File: rtl/crop_ctrl.sv
// Crop-window sequencer: validates window configs, applies them at frame boundaries,
// tracks raster position and forwards in-window pixels through one output register.
module crop_ctrl #(
    parameter int PIXEL_BIT_WIDTH = 12,
    parameter int IN_ROWS         = 40,
    parameter int IN_COLS         = 40
) (
    input logic   clk,
    input logic   reset,
    crop_if.slave bus
);
    localparam int COL_W = $clog2(IN_COLS + 1);
    localparam int ROW_W = $clog2(IN_ROWS + 1);

    localparam logic [COL_W:0]   X_LIM  = (COL_W + 1)'(IN_COLS);
    localparam logic [ROW_W:0]   Y_LIM  = (ROW_W + 1)'(IN_ROWS);
    localparam logic [COL_W-1:0] X_LAST = COL_W'(IN_COLS - 1);
    localparam logic [ROW_W-1:0] Y_LAST = ROW_W'(IN_ROWS - 1);
    localparam logic [COL_W:0]   ONE_C  = (COL_W + 1)'(1);
    localparam logic [ROW_W:0]   ONE_R  = (ROW_W + 1)'(1);

    typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;

    typedef struct packed {
        logic [COL_W-1:0] x1;
        logic [ROW_W-1:0] y1;
        logic [COL_W-1:0] cols;
        logic [ROW_W-1:0] rows;
    } win_t;

    state_t state, state_nxt;
    win_t   win, pend_win, win_eff;
    logic   pending;

    logic [COL_W-1:0] x, x_nxt, pos_x;
    logic [ROW_W-1:0] y, y_nxt, pos_y;

    logic accept, take, sof_err, load, last;
    logic cfg_fire, cfg_legal;
    logic [COL_W:0] cfg_x_end, x_end;
    logic [ROW_W:0] cfg_y_end, y_end;
    logic in_x, in_y, hit, col_last, row_last, at_sof;

    logic [PIXEL_BIT_WIDTH-1:0] pix_q;
    logic out_vld, sof_q, eol_q, eof_q;
    logic cfg_err_q, frame_err_q, frame_done_q;

    assign bus.in_ready   = !out_vld || bus.out_ready;
    assign bus.cfg_ready  = !pending;
    assign bus.pixel_out  = pix_q;
    assign bus.out_valid  = out_vld;
    assign bus.out_sof    = sof_q;
    assign bus.out_eol    = eol_q;
    assign bus.out_eof    = eof_q;
    assign bus.cfg_err    = cfg_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.frame_done = frame_done_q;
    assign bus.active     = (state == ACTIVE);

    assign accept   = bus.in_valid && bus.in_ready;
    assign cfg_fire = bus.cfg_valid && !pending;

    // Extent sums carry one extra bit so x1+cols cannot wrap past the frame edge.
    always_comb begin
        cfg_x_end = {1'b0, bus.cfg_x1} + {1'b0, bus.cfg_cols};
        cfg_y_end = {1'b0, bus.cfg_y1} + {1'b0, bus.cfg_rows};
        cfg_legal = (bus.cfg_cols != '0) && (bus.cfg_rows != '0) &&
                    (cfg_x_end <= X_LIM) && (cfg_y_end <= Y_LIM);
    end

    always_comb begin
        state_nxt = state;
        x_nxt     = x;
        y_nxt     = y;
        pos_x     = x;
        pos_y     = y;
        take      = 1'b0;
        sof_err   = 1'b0;
        load      = 1'b0;
        last      = 1'b0;
        unique case (state)
            IDLE: begin
                if (pending) begin
                    load      = 1'b1;
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (accept && bus.in_sof) begin
                    take  = 1'b1;
                    pos_x = '0;
                    pos_y = '0;
                end
            end
            ACTIVE: begin
                if (accept) begin
                    take = 1'b1;
                    // Early sof restarts the frame on this very beat.
                    if (bus.in_sof && (x != '0 || y != '0)) begin
                        sof_err = 1'b1;
                        pos_x   = '0;
                        pos_y   = '0;
                        load    = pending;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (take) begin
            last = (pos_x == X_LAST) && (pos_y == Y_LAST);
            if (last) begin
                x_nxt     = '0;
                y_nxt     = '0;
                load      = load | pending;
                state_nxt = ARMED;
            end else if (pos_x == X_LAST) begin
                x_nxt     = '0;
                y_nxt     = pos_y + 1'b1;
                state_nxt = ACTIVE;
            end else begin
                x_nxt     = pos_x + 1'b1;
                y_nxt     = pos_y;
                state_nxt = ACTIVE;
            end
        end
    end

    // A resync that loads a pending window starts the new frame, so that window applies here.
    assign win_eff = (sof_err && pending) ? pend_win : win;

    always_comb begin
        x_end    = {1'b0, win_eff.x1} + {1'b0, win_eff.cols};
        y_end    = {1'b0, win_eff.y1} + {1'b0, win_eff.rows};
        in_x     = (pos_x >= win_eff.x1) && ({1'b0, pos_x} < x_end);
        in_y     = (pos_y >= win_eff.y1) && ({1'b0, pos_y} < y_end);
        hit      = take && in_x && in_y;
        col_last = ({1'b0, pos_x} == x_end - ONE_C);
        row_last = ({1'b0, pos_y} == y_end - ONE_R);
        at_sof   = (pos_x == win_eff.x1) && (pos_y == win_eff.y1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            pending      <= 1'b0;
            win          <= '0;
            pend_win     <= '0;
            x            <= '0;
            y            <= '0;
            cfg_err_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            x            <= x_nxt;
            y            <= y_nxt;
            cfg_err_q    <= cfg_fire && !cfg_legal;
            frame_err_q  <= sof_err;
            frame_done_q <= last;
            if (load)
                win <= pend_win;
            pending <= (pending && !load) || (cfg_fire && cfg_legal);
            if (cfg_fire && cfg_legal)
                pend_win <= '{x1: bus.cfg_x1, y1: bus.cfg_y1,
                              cols: bus.cfg_cols, rows: bus.cfg_rows};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_vld <= 1'b0;
            pix_q   <= '0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else if (hit) begin
            out_vld <= 1'b1;
            pix_q   <= bus.pixel_in;
            sof_q   <= at_sof;
            eol_q   <= col_last;
            eof_q   <= col_last && row_last;
        end else if (bus.out_ready) begin
            out_vld <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_crop_ctrl.sv
// Randomized bench for crop_ctrl: a frame-level reference model queues expected output
// beats, and an independent monitor pops and compares them as the DUT hands them off.
module tb_crop_ctrl;
    localparam int PW = 12;
    localparam int R  = 40;
    localparam int C  = 40;
    localparam int FR = R * C;
    localparam int CW = $clog2(C + 1);
    localparam int RW = $clog2(R + 1);

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    crop_if #(.PIXEL_BIT_WIDTH(PW), .IN_ROWS(R), .IN_COLS(C)) bus ();
    crop_ctrl #(.PIXEL_BIT_WIDTH(PW), .IN_ROWS(R), .IN_COLS(C)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct {
        logic [PW-1:0] pix;
        bit sof, eol, eof;
    } beat_t;
    beat_t sb_q[$];

    int checks = 0, failures = 0;
    int n_out = 0, n_eof = 0, n_done = 0, n_ferr = 0;

    // reference model: mode 0 idle, 1 armed, 2 active; position kept as a raster index
    int m_mode = 0, m_p = 0;
    bit m_pend = 0, m_ov = 0, m_acc = 0, m_cfire = 0;
    int p_x1, p_y1, p_c, p_r, w_x1, w_y1, w_c, w_r;
    bit e_cerr = 0, e_ferr = 0, e_done = 0, e_act = 0, m_hit = 0;

    // stimulus state
    bit rst_req = 1, want_cfg = 0;
    int c_x1, c_y1, c_c, c_r;
    int gen_pos = 0, inject_at = -1, vprob = 100, ready_mode = 0, hold_cnt = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_pend();
        w_x1 = p_x1; w_y1 = p_y1; w_c = p_c; w_r = p_r;
        m_pend = 0;
    endtask

    task automatic take_beat(int p);
        int x = p % C;
        int y = p / C;
        beat_t b;
        if (y >= w_y1 && y < w_y1 + w_r && x >= w_x1 && x < w_x1 + w_c) begin
            b.pix = bus.pixel_in;
            b.sof = (x == w_x1) && (y == w_y1);
            b.eol = (x == w_x1 + w_c - 1);
            b.eof = b.eol && (y == w_y1 + w_r - 1);
            sb_q.push_back(b);
            m_hit = 1;
        end
        if (p == FR - 1) begin
            e_done = 1;
            m_p = 0;
            if (m_pend) load_pend();
            m_mode = 1;
        end else begin
            m_p = p + 1;
            m_mode = 2;
        end
    endtask

    task automatic model_cycle();
        bit irdy, legal;
        int x1, y1, cc, rr, p;
        if (reset) begin
            m_mode = 0; m_p = 0; m_pend = 0; m_ov = 0; m_acc = 0; m_cfire = 0;
            e_cerr = 0; e_ferr = 0; e_done = 0; e_act = 0;
            sb_q.delete();
            return;
        end
        irdy = !m_ov || bus.out_ready;
        chk("active", bus.active, e_act);
        chk("cfg_err", bus.cfg_err, e_cerr);
        chk("frame_err", bus.frame_err, e_ferr);
        chk("frame_done", bus.frame_done, e_done);
        chk("cfg_ready", bus.cfg_ready, !m_pend);
        chk("out_valid", bus.out_valid, m_ov);
        chk("in_ready", bus.in_ready, irdy);

        m_acc = bus.in_valid && irdy;
        m_cfire = bus.cfg_valid && !m_pend;
        x1 = int'(bus.cfg_x1); y1 = int'(bus.cfg_y1);
        cc = int'(bus.cfg_cols); rr = int'(bus.cfg_rows);
        legal = cc >= 1 && rr >= 1 && x1 + cc <= C && y1 + rr <= R;
        e_cerr = m_cfire && !legal;
        e_ferr = 0; e_done = 0; m_hit = 0;

        case (m_mode)
            0: if (m_pend) begin load_pend(); m_mode = 1; end
            1: if (m_acc && bus.in_sof) take_beat(0);
            default: if (m_acc) begin
                p = m_p;
                if (bus.in_sof && p != 0) begin
                    e_ferr = 1;
                    p = 0;
                    if (m_pend) load_pend();
                end
                take_beat(p);
            end
        endcase

        m_ov = m_hit ? 1'b1 : (bus.out_ready ? 1'b0 : m_ov);
        if (m_cfire && legal) begin
            m_pend = 1; p_x1 = x1; p_y1 = y1; p_c = cc; p_r = rr;
        end
        e_act = (m_mode == 2);
    endtask

    task automatic step();
        @(negedge clk);
        reset = rst_req;
        bus.cfg_valid = want_cfg;
        bus.cfg_x1    = CW'(c_x1);
        bus.cfg_y1    = RW'(c_y1);
        bus.cfg_cols  = CW'(c_c);
        bus.cfg_rows  = RW'(c_r);
        bus.in_valid  = ($urandom_range(99) < vprob);
        bus.pixel_in  = PW'($urandom);
        bus.in_sof    = bus.in_valid ? (gen_pos == 0 || gen_pos == inject_at)
                                     : 1'($urandom_range(1));
        case (ready_mode)
            0: bus.out_ready = 1'b1;
            1: bus.out_ready = 1'($urandom_range(1));
            default: begin
                bus.out_ready = !(m_ov && hold_cnt < 5);
                if (m_ov && hold_cnt < 5) hold_cnt++;
            end
        endcase
        #1;
        model_cycle();
        if (m_acc) begin
            if (gen_pos == inject_at && gen_pos != 0) begin
                inject_at = -1;
                gen_pos = 1;
            end else begin
                gen_pos = (gen_pos + 1) % FR;
            end
        end
        if (m_cfire || reset) want_cfg = 0;
        if (reset) gen_pos = 0;
    endtask

    task automatic post_cfg(int x1, int y1, int cc, int rr);
        c_x1 = x1; c_y1 = y1; c_c = cc; c_r = rr;
        want_cfg = 1;
    endtask

    task automatic run_beats(int n);
        int got = 0, cyc = 0;
        while (got < n && cyc < 8 * n + 200) begin
            step();
            if (m_acc) got++;
            cyc++;
        end
        if (got < n) begin
            checks++;
            failures++;
            $display("FAIL run_beats_timeout: got %0d beats need %0d", got, n);
        end
    endtask

    task automatic idle(int n);
        int sv = vprob;
        vprob = 0;
        repeat (n) step();
        vprob = sv;
    endtask

    task automatic do_reset();
        rst_req = 1;
        repeat (2) step();
        rst_req = 0;
    endtask

    // Output monitor: pops the scoreboard on every accepted beat and checks stall stability.
    initial begin
        bit stall = 0;
        logic [PW+2:0] held = '0;
        beat_t e;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                stall = 0;
                continue;
            end
            if (bus.frame_done) n_done++;
            if (bus.frame_err) n_ferr++;
            if (stall) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_data", {bus.pixel_out, bus.out_sof, bus.out_eol, bus.out_eof}, held);
            end
            if (bus.out_valid && bus.out_ready) begin
                stall = 0;
                n_out++;
                if (bus.out_eof) n_eof++;
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got pix %0h with no beat expected", bus.pixel_out);
                end else begin
                    e = sb_q.pop_front();
                    chk("beat_pix", bus.pixel_out, e.pix);
                    chk("beat_markers", {bus.out_sof, bus.out_eol, bus.out_eof},
                        {e.sof, e.eol, e.eof});
                end
            end else if (bus.out_valid) begin
                stall = 1;
                held = {bus.pixel_out, bus.out_sof, bus.out_eol, bus.out_eof};
            end else begin
                stall = 0;
            end
        end
    end

    initial begin
        int o0, d0, f0, e0;
        bus.cfg_valid = 0; bus.in_valid = 0; bus.in_sof = 0; bus.out_ready = 1;
        bus.pixel_in = '0; bus.cfg_x1 = '0; bus.cfg_y1 = '0; bus.cfg_cols = '0; bus.cfg_rows = '0;
        c_x1 = 0; c_y1 = 0; c_c = 0; c_r = 0;
        p_x1 = 0; p_y1 = 0; p_c = 0; p_r = 0; w_x1 = 0; w_y1 = 0; w_c = 0; w_r = 0;
        repeat (3) step();
        rst_req = 0;

        // centred 20x20 window, one full frame
        post_cfg(10, 10, 20, 20);
        idle(3);
        o0 = n_out; d0 = n_done; e0 = n_eof;
        run_beats(FR);
        idle(4);
        chk("t1_beats", n_out - o0, 400);
        chk("t1_done", n_done - d0, 1);
        chk("t1_eof", n_eof - e0, 1);

        // window overhanging the right edge is rejected; nothing is forwarded
        do_reset();
        post_cfg(30, 0, 11, 5);
        idle(3);
        o0 = n_out;
        run_beats(FR);
        idle(4);
        chk("t2_beats", n_out - o0, 0);

        // single-pixel window with downstream stalled after the hit
        do_reset();
        post_cfg(0, 0, 1, 1);
        idle(3);
        ready_mode = 2; hold_cnt = 0;
        o0 = n_out;
        run_beats(FR);
        idle(4);
        ready_mode = 0;
        chk("t3_beats", n_out - o0, 1);
        chk("t3_hold", hold_cnt, 5);

        // full-frame window requested mid-frame takes over on the next frame
        do_reset();
        post_cfg(10, 10, 20, 20);
        idle(3);
        o0 = n_out;
        run_beats(FR / 2);
        post_cfg(0, 0, 40, 40);
        run_beats(FR / 2);
        idle(4);
        chk("t4_cur_frame", n_out - o0, 400);
        o0 = n_out;
        run_beats(FR);
        idle(4);
        chk("t4_next_frame", n_out - o0, FR);

        // early sof at input pixel 500 truncates the frame without eof
        inject_at = 500;
        f0 = n_ferr; e0 = n_eof; o0 = n_out;
        run_beats(FR);
        idle(4);
        chk("t5_ferr", n_ferr - f0, 1);
        chk("t5_no_eof", n_eof - e0, 0);
        chk("t5_beats", n_out - o0, FR);
        run_beats(500);
        idle(4);
        chk("t5_eof_later", n_eof - e0, 1);

        // reset with an output beat in flight
        run_beats(100);
        chk("t6_pre_valid", bus.out_valid, 1);
        rst_req = 1;
        step();
        rst_req = 0;
        step();
        chk("t6_out_valid", bus.out_valid, 0);
        chk("t6_active", bus.active, 0);
        chk("t6_cfg_ready", bus.cfg_ready, 1);
        o0 = n_out;
        run_beats(FR);
        idle(4);
        chk("t6_beats", n_out - o0, 0);

        // random windows, traffic and backpressure
        ready_mode = 1;
        for (int i = 0; i < 10; i++) begin
            int x1 = $urandom_range(C - 1);
            int y1 = $urandom_range(R - 1);
            vprob = $urandom_range(100, 50);
            if ($urandom_range(9) < 2)
                post_cfg($urandom_range(63), $urandom_range(63), $urandom_range(63), 0);
            else
                post_cfg(x1, y1, $urandom_range(C - x1, 1), $urandom_range(R - y1, 1));
            if ($urandom_range(3) == 0) inject_at = $urandom_range(FR - 1, 1);
            if ($urandom_range(7) == 0) do_reset();
            run_beats($urandom_range(2000, 400));
        end

        ready_mode = 0;
        vprob = 100;
        idle(20);
        chk("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
